pmem_arbiter_n: RTL
===================

PMEM_ARBITER_N -- requirements
Module: pmem_arbiter_n

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of cache-side requester ports, legal range 2..8.
REQ-002 Parameter ADDR_W, default 16, physical address width.
REQ-003 Parameter LINE_W, default 128, cache line width.
REQ-004 Parameter PRIORITY_MODE, default 0; 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 port_read  input  NUM_PORTS  per-port line read request, held until that port's resp.
REQ-008 port_write  input  NUM_PORTS  per-port line write request, held until that port's resp.
REQ-009 port_address  input  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 port_wdata  input  NUM_PORTS*LINE_W  per-port write line, packed as above.
REQ-011 port_resp  output  NUM_PORTS  one-hot completion pulse to the granted port.
REQ-012 port_rdata  output  LINE_W  read line, broadcast to all ports, equal to pmem_rdata.
REQ-013 pmem_read / pmem_write  output  1 each  memory-side request strobes.
REQ-014 pmem_address  output  ADDR_W  registered address of the granted transaction.
REQ-015 pmem_wdata  output  LINE_W  registered write line of the granted transaction.
REQ-016 pmem_resp  input  1  memory completion, one-cycle pulse.
REQ-017 pmem_rdata  input  LINE_W  memory read line, valid while pmem_resp is high.
REQ-018 busy  output  1  high while a transaction is outstanding.
REQ-019 proto_err  output  1  sticky flag for a port asserting read and write together.

Function
REQ-020 The FSM SHALL have two states, IDLE and BUSY.
REQ-021 In IDLE, a port is requesting if port_read[i] or port_write[i] is high.
REQ-022 In IDLE with at least one requesting port, the block SHALL select one port at the clock edge, enter BUSY, and register grant index, address, wdata and op.
REQ-023 Round-robin mode SHALL search from last_grant+1 upward, wrapping modulo NUM_PORTS, and SHALL update last_grant to the selected port.
REQ-024 Fixed mode SHALL select the lowest-index requesting port and SHALL leave last_grant unchanged.
REQ-025 pmem_read or pmem_write SHALL be high in every BUSY cycle, per the registered op, starting the cycle after the grant edge (1-cycle request latency).
REQ-026 A port asserting both read and write SHALL be serviced as a write, and proto_err SHALL set and hold until reset.
REQ-027 pmem_address and pmem_wdata SHALL stay constant throughout BUSY, independent of port input changes.
REQ-028 While in BUSY, port_resp[grant] SHALL equal pmem_resp combinationally; all other port_resp bits SHALL be 0.
REQ-029 On a BUSY edge with pmem_resp high, the FSM SHALL return to IDLE, and pmem_read/pmem_write SHALL be 0 in the following cycle.
REQ-030 pmem_resp in IDLE SHALL be ignored: no port_resp pulse and no state change.
REQ-031 A port's request arriving while BUSY SHALL wait; arbitration happens only in IDLE, giving exactly one IDLE cycle between back-to-back transactions.
REQ-032 busy SHALL equal (state == BUSY).

Reset
REQ-033 Asserting rst_n low SHALL immediately force IDLE, with pmem_read, pmem_write, port_resp, busy and proto_err at 0, pmem_address and pmem_wdata at 0, and last_grant at NUM_PORTS-1 so that port 0 wins first.
REQ-034 Reset during BUSY SHALL abandon the transaction with no port_resp pulse; a pmem_resp arriving after reset release SHALL be ignored per REQ-030.

Verification
REQ-035 Reset, then port0 read at 0x1230 -> pmem_read=1 and pmem_address=0x1230 the next cycle; pmem_resp with rdata 0xA5..A5 -> port_resp=2'b01 and port_rdata=0xA5..A5 in the same cycle.
REQ-036 Round-robin, NUM_PORTS=4, all ports requesting continuously -> grant order 0,1,2,3,0 with one IDLE cycle between transactions.
REQ-037 Fixed mode, ports 1 and 3 requesting -> port 1 served, then port 3; port 0 arriving during port 3 BUSY is served next.
REQ-038 Port 2 write of 0xDEAD..BEEF at 0x0040 while its port_address changes mid-BUSY -> pmem_address stays 0x0040 and pmem_wdata stays unchanged.
REQ-039 rst_n low during BUSY -> outputs 0 immediately; a late pmem_resp produces no port_resp.
REQ-040 Port 1 asserts read and write together -> write issued and proto_err=1 until reset.

Source files
------------

// File: rtl/pmem_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_arbiter_n
//  Purpose  : Arbitrates NUM_PORTS cache-side line read/write requesters onto
//             a single physical-memory port. One transaction is outstanding
//             at a time. Arbitration is round-robin or fixed priority.
//  Ports    :
//    clk, rst_n            - clock, asynchronous active-low reset
//    port_read/port_write  - per-port request strobes, held until port_resp
//    port_address          - per-port address, port i at [i*ADDR_W +: ADDR_W]
//    port_wdata            - per-port write line, port i at [i*LINE_W +: LINE_W]
//    port_resp             - one-hot completion pulse to the granted port
//    port_rdata            - read line broadcast to every port
//    pmem_read/pmem_write  - memory-side request strobes (registered)
//    pmem_address/wdata    - registered address / line of the granted request
//    pmem_resp/pmem_rdata  - memory completion pulse and read line
//    busy                  - a transaction is outstanding
//    proto_err             - sticky: some port asserted read and write together
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter_n #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_W        = 16,
    parameter int LINE_W        = 128,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          port_read,
    input  logic [NUM_PORTS-1:0]          port_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
    input  logic [NUM_PORTS*LINE_W-1:0]   port_wdata,
    output logic [NUM_PORTS-1:0]          port_resp,
    output logic [LINE_W-1:0]             port_rdata,
    output logic                          pmem_read,
    output logic                          pmem_write,
    output logic [ADDR_W-1:0]             pmem_address,
    output logic [LINE_W-1:0]             pmem_wdata,
    input  logic                          pmem_resp,
    input  logic [LINE_W-1:0]             pmem_rdata,
    output logic                          busy,
    output logic                          proto_err
);

    localparam int c_idx_w = $clog2(NUM_PORTS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_grant;
    logic [c_idx_w-1:0]   r_last_grant;
    logic [ADDR_W-1:0]    r_addr;
    logic [LINE_W-1:0]    r_wdata;
    logic                 r_pmem_read;
    logic                 r_pmem_write;
    logic                 r_proto_err;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_conflict;
    logic [c_idx_w-1:0]   w_sel;
    logic                 w_found;
    logic [ADDR_W-1:0]    w_addr;
    logic [LINE_W-1:0]    w_wdata;
    logic                 w_write;

    assign w_req      = port_read | port_write;
    assign w_conflict = |(port_read & port_write);

    // Winner selection. In round-robin mode the first pass only considers
    // ports above last_grant; if none of those request, the plain
    // lowest-index pass picks the wrapped-around winner, which is exactly
    // the fixed-priority search as well.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        if (PRIORITY_MODE == 0) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!w_found && w_req[i] && (c_idx_w'(i) > r_last_grant)) begin
                    w_sel   = c_idx_w'(i);
                    w_found = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_req[i]) begin
                w_sel   = c_idx_w'(i);
                w_found = 1'b1;
            end
        end
    end

    // Fields of the selected port. A port raising both strobes is a write.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_sel == c_idx_w'(i)) begin
                w_addr  = port_address[i*ADDR_W +: ADDR_W];
                w_wdata = port_wdata[i*LINE_W +: LINE_W];
                w_write = port_write[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_idx_w'(NUM_PORTS - 1);
            r_addr       <= '0;
            r_wdata      <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_conflict) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    // pmem_resp is deliberately not looked at here.
                    if (w_found) begin
                        r_state      <= BUSY;
                        r_grant      <= w_sel;
                        r_addr       <= w_addr;
                        r_wdata      <= w_wdata;
                        r_pmem_read  <= ~w_write;
                        r_pmem_write <= w_write;
                        if (PRIORITY_MODE == 0) begin
                            r_last_grant <= w_sel;
                        end
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Completion is passed straight through to the granted port so the
    // requester sees it in the same cycle as the memory.
    always_comb begin
        port_resp = '0;
        if (r_state == BUSY) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_resp[i] = pmem_resp && (r_grant == c_idx_w'(i));
            end
        end
    end

    assign port_rdata   = pmem_rdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign busy         = (r_state == BUSY);
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire
